// File: rtl/way_rr_arbiter_pkg.sv
// Shared definitions for the way arbiters: index width, pointer wrap and output-stage state.
package way_rr_arbiter_pkg;

   // Output register occupancy.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Index/pointer width; a single-way arbiter still carries a 1-bit index.
   function automatic int unsigned way_log2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Round-robin pointer advance: one past the granted way, wrapping at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/way_rr_arbiter_mux_decoded.sv
// One-hot select of one payload out of a flattened payload vector.
//  flatted_in : N payloads of W bits, way i at [i*W +: W]
//  select_in  : one-hot way select (all-zero gives zero output)
//  data_out   : selected payload (combinational)
module way_rr_arbiter_mux_decoded #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NUMBER_WAY = 8
) (
   input  logic [WIDTH*NUMBER_WAY-1:0] flatted_in,
   input  logic [NUMBER_WAY-1:0]       select_in,
   output logic [WIDTH-1:0]            data_out
);

   // AND-OR mux: relies on select_in being one-hot or zero.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < int'(NUMBER_WAY); i++) begin
         if (select_in[i]) begin
            data_out = data_out | flatted_in[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/way_rr_arbiter.sv
// Round-robin arbiter sharing one way-select datapath among NUMBER_WAY requesters,
// with a single registered valid/ready output stage.
//  clk_in / reset_n_in  : clock, synchronous active-low reset
//  request_valid_in     : per-way valid
//  request_flatted_in   : per-way payloads, way i at [i*W +: W]
//  request_ack_out      : one-hot acceptance this cycle (combinational)
//  out_valid_out        : output register holds a payload
//  out_data_out         : registered payload
//  out_index_out        : index of the way that produced out_data_out
//  out_grant_out        : one-hot of out_index_out, zero when empty
//  out_ready_in         : consumer pops when out_valid_out & out_ready_in
module way_rr_arbiter
   import way_rr_arbiter_pkg::*;
#(
   parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 32,
   parameter int unsigned NUMBER_WAY               = 8
) (
   input  logic                                           clk_in,
   input  logic                                           reset_n_in,
   input  logic [NUMBER_WAY-1:0]                          request_valid_in,
   input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUMBER_WAY-1:0] request_flatted_in,
   output logic [NUMBER_WAY-1:0]                          request_ack_out,
   output logic                                           out_valid_out,
   output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]            out_data_out,
   output logic [way_log2(NUMBER_WAY)-1:0]                out_index_out,
   output logic [NUMBER_WAY-1:0]                          out_grant_out,
   input  logic                                           out_ready_in
);

   localparam int unsigned W               = SINGLE_WAY_WIDTH_IN_BITS;
   localparam int unsigned N               = NUMBER_WAY;
   localparam int unsigned NUMBER_WAY_LOG2 = way_log2(NUMBER_WAY);

   out_state_t                 state;
   out_state_t                 state_next;
   logic [NUMBER_WAY_LOG2-1:0] rr_ptr;
   logic [N-1:0]               masked;
   logic [N-1:0]               pick_vec;
   logic [N-1:0]               grant;
   logic [NUMBER_WAY_LOG2-1:0] grant_idx;
   logic                       accept;
   logic                       pop;
   logic [W-1:0]               sel_data;

   // Arbitration: lowest valid at or above rr_ptr, else lowest valid overall (wrap).
   always_comb begin
      masked    = '0;
      grant     = '0;
      grant_idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         masked[i] = request_valid_in[i] && (i >= int'(rr_ptr));
      end
      pick_vec = (|masked) ? masked : request_valid_in;
      // Descending scan so the lowest set bit is the last one written.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            grant_idx = NUMBER_WAY_LOG2'(i);
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         grant[i] = pick_vec[i] && (grant_idx == NUMBER_WAY_LOG2'(i));
      end
   end

   // Accept whenever the output slot is free or being freed this cycle; ack is masked in reset.
   assign accept          = reset_n_in && (|request_valid_in) && ((state == OUT_EMPTY) || out_ready_in);
   assign pop             = (state == OUT_FULL) && out_ready_in;
   assign request_ack_out = accept ? grant : '0;

   way_rr_arbiter_mux_decoded #(
      .WIDTH      (W),
      .NUMBER_WAY (N)
   ) u_mux (
      .flatted_in (request_flatted_in),
      .select_in  (grant),
      .data_out   (sel_data)
   );

   // Output-stage state register.
   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Output-stage next state.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = OUT_FULL;
      end else if (pop) begin
         state_next = OUT_EMPTY;
      end
   end

   // Output-stage decode.
   always_comb begin
      out_valid_out = (state == OUT_FULL);
   end

   // Payload/index capture and round-robin pointer; data/index hold on a plain pop.
   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         out_data_out  <= '0;
         out_index_out <= '0;
         out_grant_out <= '0;
         rr_ptr        <= '0;
      end else if (accept) begin
         out_data_out  <= sel_data;
         out_index_out <= grant_idx;
         out_grant_out <= grant;
         rr_ptr        <= NUMBER_WAY_LOG2'(wrap_inc(32'(grant_idx), N));
      end else if (pop) begin
         out_grant_out <= '0;
      end
   end

endmodule

// File: tb/tb_way_rr_arbiter.sv
// Directed bench for way_rr_arbiter (W=32, N=8): reset, round-robin order, wrap/skip,
// backpressure, pass-through and reset during a stall.
module tb_way_rr_arbiter;

   localparam int unsigned W = 32;
   localparam int unsigned N = 8;

   logic           clk_in = 1'b0;
   logic           reset_n_in;
   logic [N-1:0]   request_valid_in;
   logic [W*N-1:0] request_flatted_in;
   logic [N-1:0]   request_ack_out;
   logic           out_valid_out;
   logic [W-1:0]   out_data_out;
   logic [2:0]     out_index_out;
   logic [N-1:0]   out_grant_out;
   logic           out_ready_in;

   int total = 0;
   int bad   = 0;

   way_rr_arbiter #(
      .SINGLE_WAY_WIDTH_IN_BITS (W),
      .NUMBER_WAY               (N)
   ) dut (
      .clk_in             (clk_in),
      .reset_n_in         (reset_n_in),
      .request_valid_in   (request_valid_in),
      .request_flatted_in (request_flatted_in),
      .request_ack_out    (request_ack_out),
      .out_valid_out      (out_valid_out),
      .out_data_out       (out_data_out),
      .out_index_out      (out_index_out),
      .out_grant_out      (out_grant_out),
      .out_ready_in       (out_ready_in)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [W-1:0] payload(input int i);
      return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Inputs are changed just after a rising edge; comb ack is sampled at the falling edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input int idx, input logic [N-1:0] g);
      check({tag, ".valid"}, 64'(out_valid_out), 64'(v));
      check({tag, ".index"}, 64'(out_index_out), 64'(idx));
      check({tag, ".data"},  64'(out_data_out),  64'(payload(idx)));
      check({tag, ".grant"}, 64'(out_grant_out), 64'(g));
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) request_flatted_in[i*W +: W] = payload(i);
      reset_n_in       = 1'b0;
      request_valid_in = 8'hFF;
      out_ready_in     = 1'b1;

      // 1: reset with all requesters valid
      step();
      step();
      @(negedge clk_in);
      check("rst.ack",   64'(request_ack_out), 64'h0);
      check("rst.valid", 64'(out_valid_out),   64'h0);
      check("rst.data",  64'(out_data_out),    64'h0);
      check("rst.index", 64'(out_index_out),   64'h0);
      check("rst.grant", 64'(out_grant_out),   64'h0);
      check("rst.ptr",   64'(dut.rr_ptr),      64'h0);
      step();
      reset_n_in = 1'b1;

      // 2: all valid, ready high: grants walk 0..7,0,1 one per cycle
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_in);
         check($sformatf("rr%0d.ack", k), 64'(request_ack_out), 64'(8'h01 << (k % 8)));
         step();
         check_out($sformatf("rr%0d", k), 1'b1, k % 8, 8'h01 << (k % 8));
      end
      check("rr.ptr", 64'(dut.rr_ptr), 64'd2);

      // 3: steer ptr to 6 via way 5, then wrap to way 0, then way 5 again
      request_valid_in = 8'h20;
      @(negedge clk_in);
      check("wrap.pre_ack", 64'(request_ack_out), 64'h20);
      step();
      check("wrap.ptr6", 64'(dut.rr_ptr), 64'd6);
      request_valid_in = 8'b0010_0001;
      @(negedge clk_in);
      check("wrap.ack0", 64'(request_ack_out), 64'h01);
      step();
      check("wrap.ptr1", 64'(dut.rr_ptr), 64'd1);
      check_out("wrap.out0", 1'b1, 0, 8'h01);
      @(negedge clk_in);
      check("wrap.ack5", 64'(request_ack_out), 64'h20);
      step();
      check("wrap.ptr6b", 64'(dut.rr_ptr), 64'd6);
      check_out("wrap.out5", 1'b1, 5, 8'h20);

      // 4: backpressure for 5 cycles, then release
      request_valid_in = 8'h04;
      out_ready_in     = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_in);
         check($sformatf("bp%0d.ack", k), 64'(request_ack_out), 64'h0);
         step();
         check_out($sformatf("bp%0d", k), 1'b1, 5, 8'h20);
         check($sformatf("bp%0d.ptr", k), 64'(dut.rr_ptr), 64'd6);
      end
      out_ready_in = 1'b1;
      @(negedge clk_in);
      check("bp.rel_ack", 64'(request_ack_out), 64'h04);
      step();
      check_out("bp.rel", 1'b1, 2, 8'h04);
      check("bp.rel_ptr", 64'(dut.rr_ptr), 64'd3);

      // 5: pass-through: pop and capture in the same cycle
      request_valid_in = 8'h10;
      @(negedge clk_in);
      check("pt.ack", 64'(request_ack_out), 64'h10);
      step();
      check_out("pt", 1'b1, 4, 8'h10);
      check("pt.ptr", 64'(dut.rr_ptr), 64'd5);

      // Pop with nothing new: valid/grant clear, data/index hold
      request_valid_in = 8'h00;
      @(negedge clk_in);
      check("pop.ack", 64'(request_ack_out), 64'h0);
      step();
      check_out("pop", 1'b0, 4, 8'h00);

      // Refill via wrap (ptr=5, only way 1 valid)
      request_valid_in = 8'h02;
      @(negedge clk_in);
      check("refill.ack", 64'(request_ack_out), 64'h02);
      step();
      check_out("refill", 1'b1, 1, 8'h02);

      // 6: stall, then reset for one cycle; held payload must never reappear
      request_valid_in = 8'h00;
      out_ready_in     = 1'b0;
      step();
      check_out("stall", 1'b1, 1, 8'h02);
      reset_n_in       = 1'b0;
      request_valid_in = 8'hFF;
      @(negedge clk_in);
      check("rst2.ack", 64'(request_ack_out), 64'h0);
      step();
      check("rst2.valid", 64'(out_valid_out), 64'h0);
      check("rst2.ptr",   64'(dut.rr_ptr),    64'h0);
      check("rst2.data",  64'(out_data_out),  64'h0);
      check("rst2.grant", 64'(out_grant_out), 64'h0);
      reset_n_in       = 1'b1;
      request_valid_in = 8'h00;
      out_ready_in     = 1'b1;
      step();
      check("rst2.after_valid", 64'(out_valid_out), 64'h0);
      check("rst2.after_data",  64'(out_data_out),  64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
